game_round_ctrl: RTL

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

---
 rtl/game_round_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for a shoot-the-target game.
// Turns the launch/shoot keys and the datapath's hit/miss pulses into
// launch/fire strobes, and tracks score, lives and the round state.
module game_round_ctrl #(
  parameter int unsigned WIN_SCORE       = 9,
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned PAUSE_FRAMES    = 60,
  parameter int unsigned HOLD_FRAMES     = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_strobe,
  input  logic       launch_key,
  input  logic       shoot_key,
  input  logic       hit,
  input  logic       miss,
  output logic       launch,
  output logic       fire,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_WIN    = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  state_t     cur, nxt;
  logic [7:0] cooldown, cooldown_d;
  logic [7:0] frm, frm_d;        // pause countdown, or hold countdown in WIN/OVER
  logic [3:0] score_d;
  logic [1:0] lives_d;
  logic       fire_d;
  logic       launch_prev, shoot_prev;
  logic       armed;             // low for the first cycle after reset
  logic       launch_edge, shoot_edge;

  // A key still held across reset release must not count as a press, so
  // edges are suppressed until the previous-level registers hold a real sample.
  assign launch_edge = armed & launch_key & ~launch_prev;
  assign shoot_edge  = armed & shoot_key  & ~shoot_prev;
  assign state       = cur;

  // Key history registers for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      launch_prev <= 1'b0;
      shoot_prev  <= 1'b0;
      armed       <= 1'b0;
    end else begin
      launch_prev <= launch_key;
      shoot_prev  <= shoot_key;
      armed       <= 1'b1;
    end
  end

  // Next-state, scoring, cooldown and frame-counter logic.
  always_comb begin
    nxt        = cur;
    score_d    = score;
    lives_d    = lives;
    cooldown_d = cooldown;
    frm_d      = frm;
    fire_d     = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (launch_edge) begin
          nxt     = ST_LAUNCH;
          score_d = 4'd0;
          lives_d = 2'(LIVES_INIT);
        end
      end
      ST_LAUNCH: nxt = ST_PLAY;
      ST_PLAY: begin
        // A press while cooling down is dropped, never queued.
        if (shoot_edge && cooldown == 8'd0) begin
          fire_d     = 1'b1;
          cooldown_d = 8'(COOLDOWN_FRAMES);
        end else if (frame_strobe && cooldown != 8'd0) begin
          cooldown_d = cooldown - 8'd1;
        end
        if (hit && score != 4'(WIN_SCORE)) score_d = score + 4'd1;
        if (miss && lives != 2'd0)         lives_d = lives - 2'd1;
        // Win outranks losing the last life when both land together.
        if (hit && score == 4'(WIN_SCORE - 1)) begin
          nxt   = ST_WIN;
          frm_d = 8'(HOLD_FRAMES);
        end else if (miss && lives <= 2'd1) begin
          nxt   = ST_OVER;
          frm_d = 8'(HOLD_FRAMES);
        end else if (miss) begin
          nxt   = ST_PAUSE;
          frm_d = 8'(PAUSE_FRAMES);
        end
        if (nxt != ST_PLAY) cooldown_d = 8'd0;
      end
      ST_PAUSE: begin
        if (frame_strobe) begin
          if (frm <= 8'd1) begin
            nxt   = ST_LAUNCH;
            frm_d = 8'd0;
          end else begin
            frm_d = frm - 8'd1;
          end
        end
      end
      ST_WIN, ST_OVER: begin
        if (frm == 8'd0 && launch_edge) begin
          nxt     = ST_LAUNCH;
          score_d = 4'd0;
          lives_d = 2'(LIVES_INIT);
        end else if (frame_strobe && frm != 8'd0) begin
          frm_d = frm - 8'd1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered strobes/flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= ST_IDLE;
      score     <= 4'd0;
      lives     <= 2'd0;
      cooldown  <= 8'd0;
      frm       <= 8'd0;
      launch    <= 1'b0;
      fire      <= 1'b0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      cur       <= nxt;
      score     <= score_d;
      lives     <= lives_d;
      cooldown  <= cooldown_d;
      frm       <= frm_d;
      // LAUNCH is only entered from non-PLAY states, fire only leaves PLAY,
      // so the two strobes can never coincide.
      launch    <= (nxt == ST_LAUNCH);
      fire      <= fire_d;
      win       <= (nxt == ST_WIN);
      game_over <= (nxt == ST_OVER);
    end
  end

endmodule
